l1tlb_miss_ctrl: RTL and testbench
==================================

# l1tlb_miss_ctrl

Miss-handling controller on the L1TLB side of the L1TLB↔L2TLB link, directly upstream of `l2tlb`. It accepts L1TLB lookup misses and merges misses to the same virtual page. It tracks up to `NUM_MISS` outstanding translation requests, issues `l1tlbtol2tlb_req`, and turns `l2tlbtol1tlb_ack` into fill pulses for the L1TLB array. It also services `l2tlbtol1tlb_snoop` by invalidating the array, returning `l1tlbtol2tlb_sack`, and marking in-flight misses stale.

## Interface
- `NUM_MISS`, 4: outstanding miss entries. Power of two, 2..8. The entry index is the `rid`, zero-extended to the package `rid` width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `miss_valid` / `miss_retry`  in/out  1/1  miss request handshake from the L1TLB lookup.
- `miss_laddr`  in  39  missing virtual address; VPN = `[38:12]`.
- `l1tlbtol2tlb_req_valid` / `_retry` / `l1tlbtol2tlb_req`  out/in/out  1/1/`I_l1tlbtol2tlb_req_type`  request fields: `rid`, `laddr`.
- `l2tlbtol1tlb_ack_valid` / `_retry` / `l2tlbtol1tlb_ack`  in/out/in  1/1/`I_l2tlbtol1tlb_ack_type`  ack fields: `rid`, `hpaddr`[11], `ppaddr`[3], `dctlbe`[13].
- `l2tlbtol1tlb_snoop_valid` / `_retry` / `l2tlbtol1tlb_snoop`  in/out/in  1/1/`I_l2tlbtol1tlb_snoop_type`  snoop fields: `rid`, `hpaddr`[11].
- `l1tlbtol2tlb_sack_valid` / `_retry` / `l1tlbtol2tlb_sack`  out/in/out  1/1/`I_l1tlbtol2tlb_sack_type`  sack field: `rid`, echoed from the snoop.
- `fill_valid`  out  1  one-cycle fill pulse; the L1TLB array always accepts it.
- `fill_vpn` / `fill_hpaddr` / `fill_ppaddr` / `fill_dctlbe`  out  27/11/3/13  fill payload.
- `fill_stale`  out  1  when set, the array must not install the fill; the core replays the access.
- `inval_valid` / `inval_hpaddr`  out  1/11  one-cycle invalidate pulse to the L1TLB array.

## Operation
- **Handshake rule (all channels):** a transfer happens in any cycle with valid=1 and retry=0. A producer holds valid and payload stable while retry=1.
- **Entry states:** IDLE → SEND → WAIT → IDLE. Each entry also holds a 27-bit `vpn` and a `stale` bit.
- **Miss acceptance:**
  - If `miss_laddr` VPN matches any non-IDLE entry, the miss is merged: no allocation, no new request.
  - Otherwise the lowest-index IDLE entry is allocated into SEND with `stale`=0.
  - `miss_retry` = 1 exactly when there is no VPN match and no IDLE entry.
- **Request issue:**
  - The lowest-index SEND entry drives the request output register: `rid` = index, `laddr` = {vpn, 12'b0}.
  - On transfer the entry moves to WAIT.
  - The request register is held while `l1tlbtol2tlb_req_retry` = 1.
- **Ack handling:**
  - `l2tlbtol1tlb_ack_retry` is constant 0.
  - An ack whose `rid` is in WAIT produces a fill: `fill_vpn` = entry vpn, `fill_stale` = entry stale. The entry returns to IDLE.
  - An ack whose `rid` is not in WAIT is dropped; no fill is produced.
- **Snoop handling:**
  - A snoop is accepted when the sack output register is empty or transferring in the same cycle. Otherwise `snoop_retry` = 1.
  - On acceptance: pulse `inval_valid` with the snoop's hpaddr, load the sack register with the snoop's `rid`, and set `stale` on every SEND/WAIT entry.
- **Simultaneous snoop and ack to the same entry:** the snoop takes priority, so the resulting fill carries `fill_stale` = 1.
- **Simultaneous miss and ack freeing the only entry:** the miss is retried that cycle; the freed entry is available next cycle.
- **Reset:** asserting `reset` at any time, including mid-operation, forces all entries to IDLE and clears all output valids and registers to 0. Acks that arrive after reset are dropped by the rule above.

## Timing
- **Miss accepted at cycle T:** `l1tlbtol2tlb_req_valid` = 1 at T+1 at the earliest. Back-to-back misses issue on consecutive cycles.
- **Ack at cycle T:** `fill_valid` at T+1 (registered). The entry is IDLE and reallocatable at T+1.
- **Snoop accepted at cycle T:** `inval_valid` and `l1tlbtol2tlb_sack_valid` both at T+1. Sack throughput is one per cycle when `sack_retry` = 0.
- **Retry paths:** `miss_retry` and `snoop_retry` are combinational from current state. `ack_retry` is 0.
- **Output values in reset:** all valids are 0, all payloads are 0, and `miss_retry` = 0.

## Structure
- Shared package `scmem.vh`:
  - the four channel typedefs (`I_l1tlbtol2tlb_req_type`, `I_l2tlbtol1tlb_ack_type`, `I_l2tlbtol1tlb_snoop_type`, `I_l1tlbtol2tlb_sack_type`);
  - the `rid` width;
  - VPN/hpaddr/ppaddr/dctlbe widths.
- Sub-modules:
  - Req and sack output registers use the existing `fflop`.
  - One local sub-module, `l1tlb_miss_entry`: a single entry's state, vpn, stale bit and VPN comparator, instantiated `NUM_MISS` times.

## Test plan
- **Single miss:** miss laddr 0x12345678 → req at T+1 with rid 0, laddr 0x12345000. Then ack rid 0, hpaddr 0x3A1 → fill at T+1 with vpn 0x12345, stale 0.
- **Merge and full:** 4 distinct VPNs fill all entries. A 5th distinct VPN → `miss_retry` = 1. A repeat of VPN 0x12345 → accepted, no new req. Ack rid 2 → the 5th miss is accepted next cycle into entry 2.
- **Stale fill:** snoop rid 5, hpaddr 0x3A1 while entry 0 is in WAIT → inval 0x3A1 and sack rid 5 at T+1. A later ack rid 0 → fill with `fill_stale` = 1.
- **Same-cycle snoop and ack:** snoop and ack rid 1 in the same cycle → fill stale = 1; inval and sack both at T+1.
- **Backpressure:** hold `req_retry` = 1 for 5 cycles → req payload stable throughout, exactly one transfer. Hold `sack_retry` = 1 → a second snoop sees `snoop_retry` = 1.
- **Reset mid-flight:** assert `reset` with 3 entries in WAIT → all outputs 0. A subsequent ack rid 1 → no fill.

Source files
------------

// File: rtl/l1tlb_miss_ctrl_pkg.sv
// Shared types and widths for the L1TLB miss controller and its L1TLB<->L2TLB channels.
package l1tlb_miss_ctrl_pkg;

  localparam int unsigned RID_W    = 6;
  localparam int unsigned LADDR_W  = 39;
  localparam int unsigned PAGE_W   = 12;
  localparam int unsigned VPN_W    = LADDR_W - PAGE_W;
  localparam int unsigned HPADDR_W = 11;
  localparam int unsigned PPADDR_W = 3;
  localparam int unsigned DCTLBE_W = 13;

  typedef enum logic [1:0] {
    ENT_IDLE = 2'd0,
    ENT_SEND = 2'd1,
    ENT_WAIT = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic [RID_W-1:0]   rid;
    logic [LADDR_W-1:0] laddr;
  } I_l1tlbtol2tlb_req_type;

  typedef struct packed {
    logic [RID_W-1:0]    rid;
    logic [HPADDR_W-1:0] hpaddr;
    logic [PPADDR_W-1:0] ppaddr;
    logic [DCTLBE_W-1:0] dctlbe;
  } I_l2tlbtol1tlb_ack_type;

  typedef struct packed {
    logic [RID_W-1:0]    rid;
    logic [HPADDR_W-1:0] hpaddr;
  } I_l2tlbtol1tlb_snoop_type;

  typedef struct packed {
    logic [RID_W-1:0] rid;
  } I_l1tlbtol2tlb_sack_type;

endpackage

// File: rtl/l1tlb_miss_ctrl_if.sv
// Bundles the miss, req, ack, snoop, sack, fill and invalidate channels of the miss controller.
interface l1tlb_miss_ctrl_if;
  import l1tlb_miss_ctrl_pkg::*;

  logic                     miss_valid;
  logic                     miss_retry;
  logic [LADDR_W-1:0]       miss_laddr;

  logic                     l1tlbtol2tlb_req_valid;
  logic                     l1tlbtol2tlb_req_retry;
  I_l1tlbtol2tlb_req_type   l1tlbtol2tlb_req;

  logic                     l2tlbtol1tlb_ack_valid;
  logic                     l2tlbtol1tlb_ack_retry;
  I_l2tlbtol1tlb_ack_type   l2tlbtol1tlb_ack;

  logic                     l2tlbtol1tlb_snoop_valid;
  logic                     l2tlbtol1tlb_snoop_retry;
  I_l2tlbtol1tlb_snoop_type l2tlbtol1tlb_snoop;

  logic                     l1tlbtol2tlb_sack_valid;
  logic                     l1tlbtol2tlb_sack_retry;
  I_l1tlbtol2tlb_sack_type  l1tlbtol2tlb_sack;

  logic                     fill_valid;
  logic [VPN_W-1:0]         fill_vpn;
  logic [HPADDR_W-1:0]      fill_hpaddr;
  logic [PPADDR_W-1:0]      fill_ppaddr;
  logic [DCTLBE_W-1:0]      fill_dctlbe;
  logic                     fill_stale;

  logic                     inval_valid;
  logic [HPADDR_W-1:0]      inval_hpaddr;

  // Environment side: L1TLB lookup, L2TLB and the L1TLB array.
  modport master (
    output miss_valid, miss_laddr,
    input  miss_retry,
    input  l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req,
    output l1tlbtol2tlb_req_retry,
    output l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack,
    input  l2tlbtol1tlb_ack_retry,
    output l2tlbtol1tlb_snoop_valid, l2tlbtol1tlb_snoop,
    input  l2tlbtol1tlb_snoop_retry,
    input  l1tlbtol2tlb_sack_valid, l1tlbtol2tlb_sack,
    output l1tlbtol2tlb_sack_retry,
    input  fill_valid, fill_vpn, fill_hpaddr, fill_ppaddr, fill_dctlbe, fill_stale,
    input  inval_valid, inval_hpaddr
  );

  // Controller side.
  modport slave (
    input  miss_valid, miss_laddr,
    output miss_retry,
    output l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req,
    input  l1tlbtol2tlb_req_retry,
    input  l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack,
    output l2tlbtol1tlb_ack_retry,
    input  l2tlbtol1tlb_snoop_valid, l2tlbtol1tlb_snoop,
    output l2tlbtol1tlb_snoop_retry,
    output l1tlbtol2tlb_sack_valid, l1tlbtol2tlb_sack,
    input  l1tlbtol2tlb_sack_retry,
    output fill_valid, fill_vpn, fill_hpaddr, fill_ppaddr, fill_dctlbe, fill_stale,
    output inval_valid, inval_hpaddr
  );

endinterface

// File: rtl/fflop.sv
// Single-stage valid/retry output register: loads when empty or draining, holds under retry.
module fflop #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din_valid,
  output logic         din_retry,
  input  logic [W-1:0] din,
  output logic         q_valid,
  input  logic         q_retry,
  output logic [W-1:0] q
);

  // Upstream must wait while the held value is being back-pressured.
  assign din_retry = q_valid && q_retry;

  // Capture a new value whenever the register is free or transferring this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (!din_retry) begin
      q_valid <= din_valid;
      q       <= din;
    end
  end

endmodule

// File: rtl/l1tlb_miss_ctrl_entry.sv
// One outstanding-miss slot: IDLE/SEND/WAIT state, page number, stale flag and VPN compare.
module l1tlb_miss_entry
  import l1tlb_miss_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             issue,
  input  logic             ack_hit,
  input  logic             snoop_hit,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             idle_c,
  output logic             send_c,
  output logic             wait_c,
  output logic             match_c,
  output logic [VPN_W-1:0] vpn,
  output logic             stale
);

  ent_state_e state_q;
  ent_state_e state_d;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ENT_IDLE;
    else        state_q <= state_d;
  end

  // Next state: allocate, hand the request to L2TLB, retire on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENT_IDLE: if (alloc)   state_d = ENT_SEND;
      ENT_SEND: if (issue)   state_d = ENT_WAIT;
      ENT_WAIT: if (ack_hit) state_d = ENT_IDLE;
      default:               state_d = ENT_IDLE;
    endcase
  end

  // State decodes and the merge comparator.
  always_comb begin
    idle_c  = 1'b0;
    send_c  = 1'b0;
    wait_c  = 1'b0;
    match_c = 1'b0;
    idle_c  = (state_q == ENT_IDLE);
    send_c  = (state_q == ENT_SEND);
    wait_c  = (state_q == ENT_WAIT);
    match_c = !idle_c && (vpn == lookup_vpn);
  end

  // Page number is captured on allocation; any snoop while in flight marks the translation stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpn   <= '0;
      stale <= 1'b0;
    end else if (alloc) begin
      vpn   <= lookup_vpn;
      stale <= 1'b0;
    end else if (snoop_hit && !idle_c) begin
      stale <= 1'b1;
    end
  end

endmodule

// File: rtl/l1tlb_miss_ctrl.sv
// L1TLB miss controller: merges misses, issues L2TLB requests, turns acks into fills, services snoops.
module l1tlb_miss_ctrl
  import l1tlb_miss_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MISS = 4
) (
  input logic         clk,
  input logic         reset,
  l1tlb_miss_ctrl_if.slave bus
);

  logic [NUM_MISS-1:0] alloc;
  logic [NUM_MISS-1:0] issue;
  logic [NUM_MISS-1:0] ack_hit;
  logic [NUM_MISS-1:0] idle_c;
  logic [NUM_MISS-1:0] send_c;
  logic [NUM_MISS-1:0] wait_c;
  logic [NUM_MISS-1:0] match_c;
  logic [NUM_MISS-1:0] stale_v;
  logic [VPN_W-1:0]    vpn_v [NUM_MISS];

  logic [VPN_W-1:0]        miss_vpn;
  logic                    snoop_accept;
  logic                    req_hold;
  logic                    req_fire;
  logic                    req_d_valid;
  I_l1tlbtol2tlb_req_type  req_d;
  I_l1tlbtol2tlb_sack_type sack_d;
  logic                    ack_any;
  logic [VPN_W-1:0]        fill_vpn_d;
  logic                    fill_stale_d;
  logic                    unused_page_bits;

  assign miss_vpn         = bus.miss_laddr[LADDR_W-1:PAGE_W];
  assign unused_page_bits = ^bus.miss_laddr[PAGE_W-1:0];
  assign bus.l2tlbtol1tlb_ack_retry = 1'b0;

  // Miss slots.
  for (genvar g = 0; g < int'(NUM_MISS); g++) begin : g_ent
    l1tlb_miss_entry u_ent (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc[g]),
      .issue      (issue[g]),
      .ack_hit    (ack_hit[g]),
      .snoop_hit  (snoop_accept),
      .lookup_vpn (miss_vpn),
      .idle_c     (idle_c[g]),
      .send_c     (send_c[g]),
      .wait_c     (wait_c[g]),
      .match_c    (match_c[g]),
      .vpn        (vpn_v[g]),
      .stale      (stale_v[g])
    );
  end

  // Merge on any in-flight VPN match, else allocate the lowest idle slot, else retry.
  always_comb begin
    logic                have_idle;
    logic                any_match;
    logic [NUM_MISS-1:0] first_idle;
    have_idle  = 1'b0;
    first_idle = '0;
    any_match  = |match_c;
    for (int i = 0; i < int'(NUM_MISS); i++) begin
      if (idle_c[i] && !have_idle) begin
        first_idle[i] = 1'b1;
        have_idle     = 1'b1;
      end
    end
    bus.miss_retry = !any_match && !have_idle;
    alloc = (bus.miss_valid && !any_match && have_idle) ? first_idle : '0;
  end

  // Next request: lowest slot that will still be SEND next cycle, with a bypass for a fresh allocation.
  always_comb begin
    req_fire    = bus.l1tlbtol2tlb_req_valid && !req_hold;
    req_d_valid = 1'b0;
    req_d       = '0;
    issue       = '0;
    for (int i = 0; i < int'(NUM_MISS); i++) begin
      issue[i] = req_fire && (bus.l1tlbtol2tlb_req.rid == RID_W'(i));
      if (((send_c[i] && !issue[i]) || alloc[i]) && !req_d_valid) begin
        req_d_valid = 1'b1;
        req_d.rid   = RID_W'(i);
        req_d.laddr = {(alloc[i] ? miss_vpn : vpn_v[i]), {PAGE_W{1'b0}}};
      end
    end
  end

  // Request output register.
  fflop #(.W($bits(I_l1tlbtol2tlb_req_type))) u_req_ff (
    .clk       (clk),
    .reset     (reset),
    .din_valid (req_d_valid),
    .din_retry (req_hold),
    .din       (req_d),
    .q_valid   (bus.l1tlbtol2tlb_req_valid),
    .q_retry   (bus.l1tlbtol2tlb_req_retry),
    .q         (bus.l1tlbtol2tlb_req)
  );

  // Sack payload echoes the snoop rid.
  always_comb begin
    sack_d       = '0;
    sack_d.rid   = bus.l2tlbtol1tlb_snoop.rid;
    snoop_accept = bus.l2tlbtol1tlb_snoop_valid && !bus.l2tlbtol1tlb_snoop_retry;
  end

  // Sack output register; its back-pressure is the snoop retry.
  fflop #(.W($bits(I_l1tlbtol2tlb_sack_type))) u_sack_ff (
    .clk       (clk),
    .reset     (reset),
    .din_valid (bus.l2tlbtol1tlb_snoop_valid),
    .din_retry (bus.l2tlbtol1tlb_snoop_retry),
    .din       (sack_d),
    .q_valid   (bus.l1tlbtol2tlb_sack_valid),
    .q_retry   (bus.l1tlbtol2tlb_sack_retry),
    .q         (bus.l1tlbtol2tlb_sack)
  );

  // Ack lookup; a snoop in the same cycle wins, so the fill is reported stale.
  always_comb begin
    ack_any      = 1'b0;
    fill_vpn_d   = '0;
    fill_stale_d = 1'b0;
    ack_hit      = '0;
    for (int i = 0; i < int'(NUM_MISS); i++) begin
      ack_hit[i] = bus.l2tlbtol1tlb_ack_valid && wait_c[i] &&
                   (bus.l2tlbtol1tlb_ack.rid == RID_W'(i));
      if (ack_hit[i]) begin
        ack_any      = 1'b1;
        fill_vpn_d   = vpn_v[i];
        fill_stale_d = stale_v[i] || snoop_accept;
      end
    end
  end

  // Fill and invalidate pulses to the L1TLB array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.fill_valid   <= 1'b0;
      bus.fill_vpn     <= '0;
      bus.fill_hpaddr  <= '0;
      bus.fill_ppaddr  <= '0;
      bus.fill_dctlbe  <= '0;
      bus.fill_stale   <= 1'b0;
      bus.inval_valid  <= 1'b0;
      bus.inval_hpaddr <= '0;
    end else begin
      bus.fill_valid  <= ack_any;
      bus.inval_valid <= snoop_accept;
      if (ack_any) begin
        bus.fill_vpn    <= fill_vpn_d;
        bus.fill_hpaddr <= bus.l2tlbtol1tlb_ack.hpaddr;
        bus.fill_ppaddr <= bus.l2tlbtol1tlb_ack.ppaddr;
        bus.fill_dctlbe <= bus.l2tlbtol1tlb_ack.dctlbe;
        bus.fill_stale  <= fill_stale_d;
      end
      if (snoop_accept) bus.inval_hpaddr <= bus.l2tlbtol1tlb_snoop.hpaddr;
    end
  end

endmodule

// File: tb/tb_l1tlb_miss_ctrl.sv
// Directed bench for l1tlb_miss_ctrl: hand-computed expectations checked with immediate assertions.
module tb_l1tlb_miss_ctrl;
  import l1tlb_miss_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   req_xfers;
  int   xfer_mark;
  logic [LADDR_W-1:0] held_laddr;

  l1tlb_miss_ctrl_if bus ();

  l1tlb_miss_ctrl #(.NUM_MISS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts request transfers as seen at the clock edge.
  always @(posedge clk) begin
    if (reset && bus.l1tlbtol2tlb_req_valid && !bus.l1tlbtol2tlb_req_retry) req_xfers++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_miss(input logic v, input logic [LADDR_W-1:0] a);
    bus.miss_valid = v;
    bus.miss_laddr = a;
  endtask

  task automatic set_ack(input logic v, input logic [RID_W-1:0] rid, input logic [HPADDR_W-1:0] hp,
                         input logic [PPADDR_W-1:0] pp, input logic [DCTLBE_W-1:0] dc);
    bus.l2tlbtol1tlb_ack_valid = v;
    bus.l2tlbtol1tlb_ack.rid    = rid;
    bus.l2tlbtol1tlb_ack.hpaddr = hp;
    bus.l2tlbtol1tlb_ack.ppaddr = pp;
    bus.l2tlbtol1tlb_ack.dctlbe = dc;
  endtask

  task automatic set_snoop(input logic v, input logic [RID_W-1:0] rid, input logic [HPADDR_W-1:0] hp);
    bus.l2tlbtol1tlb_snoop_valid = v;
    bus.l2tlbtol1tlb_snoop.rid    = rid;
    bus.l2tlbtol1tlb_snoop.hpaddr = hp;
  endtask

  task automatic check_req(input string tag, input logic v, input logic [RID_W-1:0] rid,
                           input logic [LADDR_W-1:0] laddr);
    check({tag, ".valid"}, 64'(bus.l1tlbtol2tlb_req_valid), 64'(v));
    if (v) begin
      check({tag, ".rid"},   64'(bus.l1tlbtol2tlb_req.rid),   64'(rid));
      check({tag, ".laddr"}, 64'(bus.l1tlbtol2tlb_req.laddr), 64'(laddr));
    end
  endtask

  task automatic check_fill(input string tag, input logic [VPN_W-1:0] vpn, input logic stale);
    check({tag, ".valid"}, 64'(bus.fill_valid), 64'd1);
    check({tag, ".vpn"},   64'(bus.fill_vpn),   64'(vpn));
    check({tag, ".stale"}, 64'(bus.fill_stale), 64'(stale));
  endtask

  // One ack pulse for a slot, then its fill is checked on the following cycle.
  task automatic ack_and_check(input string tag, input logic [RID_W-1:0] rid,
                               input logic [VPN_W-1:0] vpn, input logic stale);
    set_ack(1'b1, rid, 11'h0AA, 3'd1, 13'h0042);
    step();
    set_ack(1'b0, '0, '0, '0, '0);
    check_fill(tag, vpn, stale);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_valid"},   64'(bus.l1tlbtol2tlb_req_valid),  64'd0);
    check({tag, ".req"},         64'(bus.l1tlbtol2tlb_req),        64'd0);
    check({tag, ".sack_valid"},  64'(bus.l1tlbtol2tlb_sack_valid), 64'd0);
    check({tag, ".sack"},        64'(bus.l1tlbtol2tlb_sack),       64'd0);
    check({tag, ".fill_valid"},  64'(bus.fill_valid),              64'd0);
    check({tag, ".fill_vpn"},    64'(bus.fill_vpn),                64'd0);
    check({tag, ".fill_hpaddr"}, 64'(bus.fill_hpaddr),             64'd0);
    check({tag, ".fill_dctlbe"}, 64'(bus.fill_dctlbe),             64'd0);
    check({tag, ".fill_stale"},  64'(bus.fill_stale),              64'd0);
    check({tag, ".inval_valid"}, 64'(bus.inval_valid),             64'd0);
    check({tag, ".inval_hp"},    64'(bus.inval_hpaddr),            64'd0);
    check({tag, ".miss_retry"},  64'(bus.miss_retry),              64'd0);
    check({tag, ".ack_retry"},   64'(bus.l2tlbtol1tlb_ack_retry),  64'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    req_xfers = 0;
    reset     = 1'b0;
    set_miss(1'b0, '0);
    set_ack(1'b0, '0, '0, '0, '0);
    set_snoop(1'b0, '0, '0);
    bus.l1tlbtol2tlb_req_retry  = 1'b0;
    bus.l1tlbtol2tlb_sack_retry = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst0");
    reset = 1'b1;
    step();

    // Single miss and its fill
    set_miss(1'b1, 39'h0012345678);
    #1;
    check("single.miss_retry", 64'(bus.miss_retry), 64'd0);
    step();
    set_miss(1'b0, '0);
    check_req("single.req", 1'b1, 6'd0, 39'h0012345000);
    step();
    check_req("single.req_done", 1'b0, '0, '0);
    set_ack(1'b1, 6'd0, 11'h3A1, 3'd5, 13'h1ABC);
    step();
    set_ack(1'b0, '0, '0, '0, '0);
    check_fill("single.fill", 27'h0012345, 1'b0);
    check("single.fill_hpaddr", 64'(bus.fill_hpaddr), 64'h3A1);
    check("single.fill_ppaddr", 64'(bus.fill_ppaddr), 64'd5);
    check("single.fill_dctlbe", 64'(bus.fill_dctlbe), 64'h1ABC);
    step();
    check("single.fill_pulse", 64'(bus.fill_valid), 64'd0);

    // Four distinct pages fill all slots, requests on consecutive cycles
    set_miss(1'b1, 39'h0012345678);
    step();
    check_req("full.req0", 1'b1, 6'd0, 39'h0012345000);
    set_miss(1'b1, 39'h0000111ABC);
    step();
    check_req("full.req1", 1'b1, 6'd1, 39'h0000111000);
    set_miss(1'b1, 39'h0000222001);
    step();
    check_req("full.req2", 1'b1, 6'd2, 39'h0000222000);
    set_miss(1'b1, 39'h0000333FFF);
    step();
    check_req("full.req3", 1'b1, 6'd3, 39'h0000333000);
    set_miss(1'b0, '0);
    step();
    check_req("full.req_done", 1'b0, '0, '0);

    // Fifth distinct page is retried; a repeat page merges
    set_miss(1'b1, 39'h0000444123);
    #1;
    check("full.retry", 64'(bus.miss_retry), 64'd1);
    set_miss(1'b1, 39'h0012345ABC);
    #1;
    check("merge.retry", 64'(bus.miss_retry), 64'd0);
    step();
    check_req("merge.no_req", 1'b0, '0, '0);

    // Ack rid 2 alongside the fifth miss: retried this cycle, accepted into slot 2 next
    set_miss(1'b1, 39'h0000444123);
    set_ack(1'b1, 6'd2, 11'h011, 3'd2, 13'h0003);
    #1;
    check("free.retry_same_cycle", 64'(bus.miss_retry), 64'd1);
    step();
    set_ack(1'b0, '0, '0, '0, '0);
    check_fill("free.fill2", 27'h0000222, 1'b0);
    check("free.retry_next", 64'(bus.miss_retry), 64'd0);
    step();
    set_miss(1'b0, '0);
    check_req("free.req2", 1'b1, 6'd2, 39'h0000444000);
    step();
    check_req("free.req_done", 1'b0, '0, '0);

    // Snoop while slots wait: invalidate and sack next cycle, later fills stale
    set_snoop(1'b1, 6'd5, 11'h3A1);
    #1;
    check("stale.snoop_retry", 64'(bus.l2tlbtol1tlb_snoop_retry), 64'd0);
    step();
    set_snoop(1'b0, '0, '0);
    check("stale.inval_valid", 64'(bus.inval_valid), 64'd1);
    check("stale.inval_hp", 64'(bus.inval_hpaddr), 64'h3A1);
    check("stale.sack_valid", 64'(bus.l1tlbtol2tlb_sack_valid), 64'd1);
    check("stale.sack_rid", 64'(bus.l1tlbtol2tlb_sack.rid), 64'd5);
    step();
    check("stale.inval_pulse", 64'(bus.inval_valid), 64'd0);
    check("stale.sack_done", 64'(bus.l1tlbtol2tlb_sack_valid), 64'd0);
    ack_and_check("stale.fill0", 6'd0, 27'h0012345, 1'b1);
    ack_and_check("stale.fill1", 6'd1, 27'h0000111, 1'b1);
    ack_and_check("stale.fill2", 6'd2, 27'h0000444, 1'b1);
    ack_and_check("stale.fill3", 6'd3, 27'h0000333, 1'b1);

    // Ack for a slot that is not waiting is dropped
    set_ack(1'b1, 6'd1, 11'h0AA, 3'd1, 13'h0042);
    step();
    set_ack(1'b0, '0, '0, '0, '0);
    check("drop.fill_valid", 64'(bus.fill_valid), 64'd0);

    // Same-cycle snoop and ack to a fresh slot
    set_miss(1'b1, 39'h0000555000);
    step();
    set_miss(1'b1, 39'h0000666000);
    step();
    set_miss(1'b0, '0);
    check_req("same.req1", 1'b1, 6'd1, 39'h0000666000);
    step();
    set_snoop(1'b1, 6'd7, 11'h155);
    set_ack(1'b1, 6'd1, 11'h222, 3'd3, 13'h0777);
    step();
    set_snoop(1'b0, '0, '0);
    set_ack(1'b0, '0, '0, '0, '0);
    check_fill("same.fill1", 27'h0000666, 1'b1);
    check("same.inval_valid", 64'(bus.inval_valid), 64'd1);
    check("same.inval_hp", 64'(bus.inval_hpaddr), 64'h155);
    check("same.sack_valid", 64'(bus.l1tlbtol2tlb_sack_valid), 64'd1);
    check("same.sack_rid", 64'(bus.l1tlbtol2tlb_sack.rid), 64'd7);
    step();
    ack_and_check("same.fill0", 6'd0, 27'h0000555, 1'b1);

    // Request back-pressure: payload stable, exactly one transfer
    bus.l1tlbtol2tlb_req_retry = 1'b1;
    set_miss(1'b1, 39'h0000777000);
    step();
    set_miss(1'b0, '0);
    check_req("bp.req", 1'b1, 6'd0, 39'h0000777000);
    held_laddr = bus.l1tlbtol2tlb_req.laddr;
    xfer_mark  = req_xfers;
    for (int k = 0; k < 5; k++) begin
      step();
      check_req($sformatf("bp.hold%0d", k), 1'b1, 6'd0, 39'h0000777000);
    end
    bus.l1tlbtol2tlb_req_retry = 1'b0;
    step();
    check_req("bp.done", 1'b0, '0, '0);
    check("bp.xfers", 64'(req_xfers - xfer_mark), 64'd1);
    check("bp.laddr_sampled", 64'(held_laddr), 64'h0000777000);

    // Sack back-pressure blocks a second snoop
    bus.l1tlbtol2tlb_sack_retry = 1'b1;
    set_snoop(1'b1, 6'd3, 11'h010);
    step();
    check("sbp.sack_rid", 64'(bus.l1tlbtol2tlb_sack.rid), 64'd3);
    set_snoop(1'b1, 6'd4, 11'h020);
    #1;
    check("sbp.snoop_retry", 64'(bus.l2tlbtol1tlb_snoop_retry), 64'd1);
    step();
    check("sbp.sack_held", 64'(bus.l1tlbtol2tlb_sack.rid), 64'd3);
    check("sbp.no_inval", 64'(bus.inval_valid), 64'd0);
    bus.l1tlbtol2tlb_sack_retry = 1'b0;
    #1;
    check("sbp.snoop_retry_drain", 64'(bus.l2tlbtol1tlb_snoop_retry), 64'd0);
    step();
    set_snoop(1'b0, '0, '0);
    check("sbp.sack2_valid", 64'(bus.l1tlbtol2tlb_sack_valid), 64'd1);
    check("sbp.sack2_rid", 64'(bus.l1tlbtol2tlb_sack.rid), 64'd4);
    check("sbp.inval2_hp", 64'(bus.inval_hpaddr), 64'h020);
    step();
    check("sbp.sack_done", 64'(bus.l1tlbtol2tlb_sack_valid), 64'd0);

    // Reset with three slots waiting and one request pending
    set_miss(1'b1, 39'h0000888000);
    step();
    set_miss(1'b1, 39'h0000999000);
    step();
    set_miss(1'b1, 39'h0000AAA000);
    step();
    set_miss(1'b0, '0);
    check_req("mid.req3", 1'b1, 6'd3, 39'h0000AAA000);
    reset = 1'b0;
    #1;
    check_all_zero("mid.rst");
    step();
    reset = 1'b1;
    set_ack(1'b1, 6'd1, 11'h0AA, 3'd1, 13'h0042);
    step();
    set_ack(1'b0, '0, '0, '0, '0);
    check("mid.ack_dropped", 64'(bus.fill_valid), 64'd0);
    set_miss(1'b1, 39'h0000BBB000);
    step();
    set_miss(1'b0, '0);
    check_req("mid.realloc", 1'b1, 6'd0, 39'h0000BBB000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
